mux_2to1: RTL and testbench

- Registered 2:1 word selector in the RISC-V datapath; picks Num_A or Num_B per Selector and presents the result one clock later.
- Used wherever the datapath chooses between two 32-bit operands, e.g. ALU operand B, next-PC, or write-back data.
- Adds a valid qualifier so downstream stages know when Out_Mux carries a fresh selection.

---
 rtl/mux_2to1.sv | 51 +++++
 tb/tb_mux_2to1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// Registered 2:1 word selector with a valid qualifier and the selecting bit carried alongside.
// Define MUX_2TO1_SEL_COUNT_EN to add Sel_Count, a 16-bit count of captures that change the selection.
`timescale 1ns/1ps

module mux_2to1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Num_A,
   input  logic [WIDTH-1:0] Num_B,
   input  logic             Selector,
   input  logic             In_Valid,
   output logic [WIDTH-1:0] Out_Mux,
   output logic             Out_Valid,
   output logic             Out_Sel
`ifdef MUX_2TO1_SEL_COUNT_EN
   ,
   output logic [15:0]      Sel_Count
`endif
);

   logic [WIDTH-1:0] sel_word;

   assign sel_word = Selector ? Num_B : Num_A;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Out_Mux   <= '0;
         Out_Sel   <= 1'b0;
         Out_Valid <= 1'b0;
      end else begin
         Out_Valid <= In_Valid;
         if (In_Valid) begin
            Out_Mux <= sel_word;
            Out_Sel <= Selector;
         end
      end
   end

`ifdef MUX_2TO1_SEL_COUNT_EN
   // Compared against the registered Out_Sel, so the first capture after reset counts only if it selects Num_B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         Sel_Count <= 16'd0;
      else if (In_Valid && (Selector != Out_Sel))
         Sel_Count <= Sel_Count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: behavioural model checked every cycle plus literal expectations from hand-worked vectors.
`timescale 1ns/1ps

module tb_mux_2to1;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] Num_A = '0;
   logic [WIDTH-1:0] Num_B = '0;
   logic             Selector = 1'b0;
   logic             In_Valid = 1'b0;
   logic [WIDTH-1:0] Out_Mux;
   logic             Out_Valid;
   logic             Out_Sel;
`ifdef MUX_2TO1_SEL_COUNT_EN
   logic [15:0]      Sel_Count;
`endif

   int checks = 0;
   int errors = 0;

   mux_2to1 #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .Num_A(Num_A),
      .Num_B(Num_B),
      .Selector(Selector),
      .In_Valid(In_Valid),
      .Out_Mux(Out_Mux),
      .Out_Valid(Out_Valid),
      .Out_Sel(Out_Sel)
`ifdef MUX_2TO1_SEL_COUNT_EN
      ,
      .Sel_Count(Sel_Count)
`endif
   );

   always #5 clk = ~clk;

   // Model: history of captures; the last capture defines the data, valid follows the last edge.
   logic [WIDTH-1:0] exp_mux = '0;
   logic             exp_sel = 1'b0;
   logic             exp_valid = 1'b0;
   int               exp_changes = 0;
   bit               model_live = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_mux     = '0;
         exp_sel     = 1'b0;
         exp_valid   = 1'b0;
         exp_changes = 0;
         model_live  = 1'b1;
      end else if (In_Valid) begin
         if (Selector != exp_sel) exp_changes = (exp_changes + 1) % 65536;
         exp_mux   = (Selector == 1'b1) ? Num_B : Num_A;
         exp_sel   = Selector;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
   end

   task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, got, got, want, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         check("cyc_out_mux", Out_Mux, exp_mux);
         check("cyc_out_valid", {31'd0, Out_Valid}, {31'd0, exp_valid});
         check("cyc_out_sel", {31'd0, Out_Sel}, {31'd0, exp_sel});
`ifdef MUX_2TO1_SEL_COUNT_EN
         check("cyc_sel_count", {16'd0, Sel_Count}, exp_changes[WIDTH-1:0]);
`endif
      end
   end

   // Drive one cycle of inputs and return just after the following falling edge.
   task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s, input logic v);
      Num_A = a;
      Num_B = b;
      Selector = s;
      In_Valid = v;
      @(negedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [WIDTH-1:0] m, input logic v, input logic s);
      check({name, "_mux"}, Out_Mux, m);
      check({name, "_valid"}, {31'd0, Out_Valid}, {31'd0, v});
      check({name, "_sel"}, {31'd0, Out_Sel}, {31'd0, s});
   endtask

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             s;
      logic             v;
   } vec_t;

   vec_t vecs[8];

   initial begin
      // Reset with active inputs; outputs must clear before any clock edge.
      Num_A = 32'h1234_5678;
      Num_B = 32'h9ABC_DEF0;
      Selector = 1'b1;
      In_Valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      expect_out("reset_async", 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      In_Valid = 1'b0;
      @(negedge clk);
      #1;

      step(32'd3000000, 32'd4, 1'b0, 1'b1);
      expect_out("sel_a", 32'd3000000, 1'b1, 1'b0);
      step(32'd3000000, 32'd4, 1'b1, 1'b1);
      expect_out("sel_b", 32'd4, 1'b1, 1'b1);
      step(32'd902, 32'd5254513, 1'b0, 1'b1);
      expect_out("b2b_first", 32'd902, 1'b1, 1'b0);
      step(32'd902, 32'd5254513, 1'b1, 1'b1);
      expect_out("b2b_second", 32'd5254513, 1'b1, 1'b1);
      step(32'hFFFF_FFFF, 32'd5254513, 1'b0, 1'b0);
      expect_out("hold_1", 32'd5254513, 1'b0, 1'b1);
      step(32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0);
      expect_out("hold_2", 32'd5254513, 1'b0, 1'b1);

      // Selection history since reset is 0,1,0,1 -> three changes.
`ifdef MUX_2TO1_SEL_COUNT_EN
      check("count_after_vectors", {16'd0, Sel_Count}, 32'd3);
`endif

      // Reset mid-cycle, then the 0,1,1,0 sequence must count two changes.
      #2 rst = 1'b1;
      #1;
      expect_out("reset_mid", 32'd0, 1'b0, 1'b0);
`ifdef MUX_2TO1_SEL_COUNT_EN
      check("count_reset", {16'd0, Sel_Count}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      step(32'd11, 32'd22, 1'b0, 1'b1);
      expect_out("post_reset", 32'd11, 1'b1, 1'b0);
      step(32'd11, 32'd22, 1'b1, 1'b1);
      step(32'd33, 32'd44, 1'b1, 1'b1);
      expect_out("seq_third", 32'd44, 1'b1, 1'b1);
      step(32'd55, 32'd66, 1'b0, 1'b1);
      expect_out("seq_fourth", 32'd55, 1'b1, 1'b0);
`ifdef MUX_2TO1_SEL_COUNT_EN
      check("count_0110", {16'd0, Sel_Count}, 32'd2);
`endif

      // Full-width patterns, equal operands and interleaved holds.
      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};
      vecs[2] = '{32'h8000_0001, 32'h8000_0001, 1'b1, 1'b1};
      vecs[3] = '{32'h8000_0001, 32'h8000_0001, 1'b0, 1'b1};
      vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0};
      vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b1};
      vecs[6] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0};
      vecs[7] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1};
      foreach (vecs[i]) step(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].v);
      expect_out("vec_last", 32'hDEAD_BEEF, 1'b1, 1'b0);

      // Operands and selector changing every cycle.
      for (int i = 0; i < 40; i++)
         step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

      step(32'd0, 32'd0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got time %0t expected under 100000", $time);
      $fatal(1);
   end
endmodule
